// File: rtl/dmem_bridge.sv
// Data-memory bridge between the M stage and a req/addr_ok/data_ok bus: exactly one bus transaction per access.
// Optional DMEM_BRIDGE_SIZE_DECODE_EN narrows store size/address from the byte strobes.
module dmem_bridge #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memen_i,
  input  logic [3:0]    wen_i,
  input  logic [AW-1:0] paddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          uncached_i,
  input  logic          flush_i,
  input  logic          ext_stall_i,
  output logic          stall_o,
  output logic [31:0]   rdata_o,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [3:0]    data_wstrb,
  output logic [31:0]   data_wdata,
  output logic          data_uncached,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [31:0]   data_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t        state, stateNxt;
  logic          reqStart;
  logic          captureRd;
  logic [3:0]    wen_p0;
  logic [AW-1:0] paddr_p0;
  logic [31:0]   wdata_p0;
  logic          uncached_p0;
  logic [31:0]   rdata_p1;
  logic [1:0]    sizeSel;
  logic [1:0]    addrLow;
  logic          unusedLowAddr;

`ifdef DMEM_BRIDGE_SIZE_DECODE_EN
  // Returns {size, addr[1:0]}; loads and irregular strobe patterns use a full word.
  function automatic logic [3:0] sizeDecode(input logic [3:0] wen);
    case (wen)
      4'b0011: return {2'd1, 2'd0};
      4'b1100: return {2'd1, 2'd2};
      4'b0001: return {2'd0, 2'd0};
      4'b0010: return {2'd0, 2'd1};
      4'b0100: return {2'd0, 2'd2};
      4'b1000: return {2'd0, 2'd3};
      default: return {2'd2, 2'd0};
    endcase
  endfunction

  assign {sizeSel, addrLow} = sizeDecode(wen_p0);
`else
  assign sizeSel = 2'd2;
  assign addrLow = 2'd0;
`endif

  assign reqStart = (state == IDLE) && memen_i && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Flush never aborts an issued transaction; HOLD blocks reissue while M is stalled elsewhere.
  always_comb begin
    stateNxt  = state;
    captureRd = 1'b0;
    case (state)
      IDLE: if (reqStart) stateNxt = ADDR;
      ADDR: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            stateNxt  = HOLD;
            captureRd = 1'b1;
          end else begin
            stateNxt  = DATA;
          end
        end
      end
      DATA: begin
        if (data_data_ok) begin
          stateNxt  = HOLD;
          captureRd = 1'b1;
        end
      end
      HOLD: if (!ext_stall_i || flush_i) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Request stage: fields held constant for the whole bus transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_p0      <= '0;
      paddr_p0    <= '0;
      wdata_p0    <= '0;
      uncached_p0 <= 1'b0;
    end else if (reqStart) begin
      wen_p0      <= wen_i;
      paddr_p0    <= paddr_i;
      wdata_p0    <= wdata_i;
      uncached_p0 <= uncached_i;
    end
  end

  // Response stage: read register only changes on an accepted data_ok.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rdata_p1 <= '0;
    else if (captureRd) rdata_p1 <= data_rdata;
  end

  assign unusedLowAddr = ^paddr_p0[1:0];

  assign data_req      = (state == ADDR);
  assign data_wr       = |wen_p0;
  assign data_size     = sizeSel;
  assign data_addr     = {paddr_p0[AW-1:2], addrLow};
  assign data_wstrb    = wen_p0;
  assign data_wdata    = wdata_p0;
  assign data_uncached = uncached_p0;

  assign stall_o = !rst && (reqStart || (state == ADDR) || (state == DATA));
  assign rdata_o = rdata_p1;

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter AW, default 32, meaning the physical address width.
REQ-002 SHALL have port clk  in  1  single clock, all state rising-edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port memen_i  in  1  M-stage data access request from the pipeline.
REQ-005 SHALL have port wen_i  in  4  M-stage byte write strobes; 0000 means load.
REQ-006 SHALL have port paddr_i  in  AW  M-stage physical data address from the MMU.
REQ-007 SHALL have port wdata_i  in  32  M-stage store data, already byte-lane aligned.
REQ-008 SHALL have port uncached_i  in  1  MMU no-dcache flag for the current access.
REQ-009 SHALL have port flush_i  in  1  M-stage flush caused by an exception or eret.
REQ-010 SHALL have port ext_stall_i  in  1  stall of M from any other source.
REQ-011 SHALL have port stall_o  out  1  data-side stall request to the hazard unit.
REQ-012 SHALL have port rdata_o  out  32  load data returned to M/W.
REQ-013 SHALL have bus-side ports: data_req out 1, data_wr out 1, data_size out 2, data_addr out AW, data_wstrb out 4, data_wdata out 32, data_uncached out 1, data_addr_ok in 1, data_data_ok in 1, data_rdata in 32.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA, HOLD.
REQ-015 IDLE: on memen_i=1 and flush_i=0, SHALL latch the request fields (wen, paddr, wdata, uncached) and go to ADDR next cycle.
REQ-016 ADDR: SHALL drive data_req=1 from latched fields; data_wr = |wen latched; stay in ADDR until data_addr_ok=1.
REQ-017 ADDR with data_addr_ok=1 SHALL go to DATA, or to HOLD if data_data_ok=1 in the same cycle.
REQ-018 DATA: SHALL hold data_req=0; on data_data_ok=1, SHALL capture data_rdata into the read register and go to HOLD.
REQ-019 HOLD: SHALL drive rdata_o from the read register; if ext_stall_i=0 or flush_i=1, SHALL go to IDLE next cycle, otherwise stay.
REQ-020 stall_o SHALL equal (state==IDLE and memen_i and not flush_i) or state==ADDR or state==DATA; 0 in HOLD.
REQ-021 Each M-stage access SHALL issue exactly one bus request; HOLD prevents reissue while M is held by ext_stall_i.
REQ-022 flush_i in ADDR or DATA SHALL NOT abort the bus transaction; the FSM completes through HOLD, and the store or load result is discarded by the pipeline.
REQ-023 data_req SHALL only rise in ADDR, and bus outputs SHALL remain stable while data_req=1 and data_addr_ok=0.
REQ-024 A data_data_ok pulse seen in IDLE or HOLD SHALL be ignored.
REQ-025 rdata_o SHALL keep its value until the next data_data_ok capture.

Reset
REQ-026 On rst=1, the block SHALL asynchronously enter IDLE with data_req=0, stall_o=0, rdata_o=0, and all latched fields 0.
REQ-027 Reset mid-transaction SHALL return to IDLE; bus responses arriving later SHALL be ignored per REQ-024.

Configuration
REQ-028 With DMEM_BRIDGE_SIZE_DECODE_EN defined, stores SHALL decode wen: 1111 gives size 2 and addr[1:0]=00; 0011 gives size 1 and addr[1:0]=00; 1100 gives size 1 and addr[1:0]=10; a single bit at position n gives size 0 and addr[1:0]=n.
REQ-029 Under REQ-028, any other wen pattern and all loads SHALL use size 2 with addr[1:0]=00.
REQ-030 Without DMEM_BRIDGE_SIZE_DECODE_EN, data_size SHALL always be 2 and data_addr[1:0]=00; data_wstrb SHALL carry the strobes in both builds.

Verification
REQ-031 Load case: load of 0x1FC0_0010, addr_ok after 2 cycles, data_ok 3 cycles later with 0xDEADBEEF -> exactly one req; stall_o high 6 cycles; rdata_o=0xDEADBEEF in HOLD.
REQ-032 Store-byte case (macro on): store with wen=0100 to 0x0000_1003 -> data_wr=1, size=0, data_addr=0x0000_1002, wstrb=0100.
REQ-033 Same-cycle handshake: addr_ok and data_ok both 1 in the first ADDR cycle -> ADDR goes to HOLD directly; stall_o drops the next cycle.
REQ-034 Held M stage: ext_stall_i=1 for 4 cycles after completion -> FSM stays in HOLD; no second data_req; IDLE once ext_stall_i=0.
REQ-035 Flush: flush_i=1 while in DATA -> FSM waits for data_ok, then goes through HOLD to IDLE; a flush in IDLE with memen_i=1 -> no req and stall_o=0.
REQ-036 Reset: rst raised while in ADDR -> data_req=0 immediately; a data_ok pulse afterward leaves rdata_o=0.
